// File: rtl/binary_index_sequencer.sv
// binary_index_sequencer: emits the binary index of each set bit of an accepted mask, lowest first.
module binary_index_sequencer #(
  parameter int INDEX_WIDTH = 4,
  parameter int MASK_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MASK_WIDTH-1:0]  mask_in,
  input  logic                   mask_valid,
  output logic                   mask_ready,
  output logic [INDEX_WIDTH-1:0] index_out,
  output logic                   index_valid,
  input  logic                   index_ready,
  output logic                   index_last,
  output logic                   busy
);
  if (MASK_WIDTH < 1 || MASK_WIDTH > 2 ** INDEX_WIDTH) begin : g_bad_cfg
    $error("binary_index_sequencer: MASK_WIDTH must be in 1..2**INDEX_WIDTH");
  end
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;
  logic [MASK_WIDTH-1:0] pending, pending_nxt, low_bit;
  logic [INDEX_WIDTH-1:0] low_idx;
  logic last;
  always_comb begin
    low_idx = '0;
    for (int i = MASK_WIDTH - 1; i >= 0; i--)
      if (pending[i]) low_idx = INDEX_WIDTH'(i);
  end
  // Isolating the lowest set bit lets one subtraction drive both clear and last-detect.
  assign low_bit = pending & (~pending + MASK_WIDTH'(1));
  assign last    = (pending != '0) && ((pending & ~low_bit) == '0);
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    if (state == IDLE) begin
      if (mask_valid && mask_in != '0) begin
        pending_nxt = mask_in;
        state_nxt   = EMIT;
      end
    end else if (index_ready) begin
      pending_nxt = pending & ~low_bit;
      state_nxt   = last ? IDLE : EMIT;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end
  assign busy        = (state == EMIT);
  assign mask_ready  = !busy;
  assign index_valid = busy;
  assign index_out   = busy ? low_idx : '0;
  assign index_last  = busy && last;
endmodule

// File: tb/tb_binary_index_sequencer.sv
// tb_binary_index_sequencer: directed plus random stimulus against a queue-based reference model.
module tb_binary_index_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mask_in = '0;
  logic        mask_valid = 1'b0;
  logic        mask_ready;
  logic [3:0]  index_out;
  logic        index_valid;
  logic        index_ready = 1'b0;
  logic        index_last;
  logic        busy;
  int n_checks = 0;
  int n_fail = 0;
  int q[$];

  binary_index_sequencer #(.INDEX_WIDTH(4), .MASK_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .mask_in(mask_in), .mask_valid(mask_valid),
    .mask_ready(mask_ready), .index_out(index_out), .index_valid(index_valid),
    .index_ready(index_ready), .index_last(index_last), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // The model holds the indices still owed for the current mask; empty means idle.
  task automatic check(input string tag);
    logic act;
    act = q.size() != 0;
    cmp({tag, ".mask_ready"},  16'(mask_ready),  16'(!act));
    cmp({tag, ".index_valid"}, 16'(index_valid), 16'(act));
    cmp({tag, ".index_out"},   16'(index_out),   act ? 16'(q[0]) : 16'd0);
    cmp({tag, ".index_last"},  16'(index_last),  16'(act && q.size() == 1));
    cmp({tag, ".busy"},        16'(busy),        16'(act));
  endtask

  task automatic cycle(input string tag);
    check(tag);
    if (q.size() != 0) begin
      if (index_ready) void'(q.pop_front());
    end else if (mask_valid) begin
      for (int i = 0; i < 16; i++) if (mask_in[i]) q.push_back(i);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1;
    check("reset_no_clock");
    @(posedge clock); #1;
    check("reset_held");
    reset = 1'b0;
    index_ready = 1'b1;
    cycle("idle");
    mask_in = 16'h00A5; mask_valid = 1'b1;
    cycle("a5_accept");
    mask_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle("a5_emit");
    mask_in = 16'h8001; mask_valid = 1'b1;
    cycle("bp_accept");
    mask_valid = 1'b0; index_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("bp_hold");
    index_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("bp_release");
    mask_in = 16'h0000; mask_valid = 1'b1;
    cycle("zero_mask");
    mask_in = 16'h0010;
    cycle("after_zero");
    mask_valid = 1'b0;
    for (int i = 0; i < 2; i++) cycle("single4");
    mask_in = 16'h0003; mask_valid = 1'b1;
    for (int i = 0; i < 9; i++) cycle("held_valid");
    mask_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle("drain");
    mask_in = 16'hFFFF; mask_valid = 1'b1;
    cycle("ffff_accept");
    mask_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle("ffff_emit");
    reset = 1'b1;
    #1;
    q.delete();
    check("reset_mid");
    @(posedge clock); #1;
    check("reset_mid_held");
    reset = 1'b0;
    mask_in = 16'h0002; mask_valid = 1'b1;
    cycle("post_rst_accept");
    mask_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle("post_rst_emit");
    for (int i = 0; i < 400; i++) begin
      mask_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: mask_in = 16'h0000;
        1: mask_in = 16'(1 << $urandom_range(0, 15));
        default: mask_in = 16'($urandom);
      endcase
      index_ready = ($urandom_range(0, 3) != 0);
      cycle("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
